// File: rtl/imager_crop.sv
// rtl/imager_crop.sv - window crop of the tagged imager pixel stream with per-frame bypass and dimension reporting
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h5
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'h6
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'h7
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'h8
`endif

module imager_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                    clki,
    input  logic                    resetb_clki,
    input  logic                    enable,
    input  logic [DIM_WIDTH-1:0]    col_start,
    input  logic [DIM_WIDTH-1:0]    col_width,
    input  logic [DIM_WIDTH-1:0]    row_start,
    input  logic [DIM_WIDTH-1:0]    row_height,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic [DIM_WIDTH-1:0]    num_rows_out,
    output logic [DIM_WIDTH-1:0]    num_cols_out
);

    typedef enum logic {WAIT_FS, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic                    en_q, en_d;
    logic [DIM_WIDTH-1:0]    col_start_q, col_start_d, col_width_q, col_width_d;
    logic [DIM_WIDTH-1:0]    row_start_q, row_start_d, row_height_q, row_height_d;
    logic [DIM_WIDTH-1:0]    in_row_q, in_row_d, in_col_q, in_col_d;
    logic                    row_had_pix_q, row_had_pix_d;
    logic [DIM_WIDTH-1:0]    cur_cols_q, cur_cols_d, last_cols_q, last_cols_d;
    logic [DIM_WIDTH-1:0]    out_rows_q, out_rows_d;
    logic [DIM_WIDTH-1:0]    num_rows_q, num_rows_d, num_cols_q, num_cols_d;
    logic                    dvo_q, dvo_d;
    logic [`DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]   datao_q, datao_d;

    logic [DIM_WIDTH:0]      row_lim, col_lim;
    logic                    row_in, col_in;
    logic [DIM_WIDTH-1:0]    row_rel, rows_upd, cols_upd;

    // One extra bit on the limits so start+size never wraps
    assign row_lim  = {1'b0, row_start_q} + {1'b0, row_height_q};
    assign col_lim  = {1'b0, col_start_q} + {1'b0, col_width_q};
    assign row_in   = (in_row_q >= row_start_q) && ({1'b0, in_row_q} < row_lim);
    assign col_in   = (in_col_q >= col_start_q) && ({1'b0, in_col_q} < col_lim);
    assign row_rel  = in_row_q - row_start_q;
    assign rows_upd = row_had_pix_q ? out_rows_q + DIM_WIDTH'(1) : out_rows_q;
    assign cols_upd = row_had_pix_q ? cur_cols_q : last_cols_q;

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        col_start_d   = col_start_q;
        col_width_d   = col_width_q;
        row_start_d   = row_start_q;
        row_height_d  = row_height_q;
        in_row_d      = in_row_q;
        in_col_d      = in_col_q;
        row_had_pix_d = row_had_pix_q;
        cur_cols_d    = cur_cols_q;
        last_cols_d   = last_cols_q;
        out_rows_d    = out_rows_q;
        num_rows_d    = num_rows_q;
        num_cols_d    = num_cols_q;
        dvo_d         = 1'b0;
        dtypeo_d      = '0;
        datao_d       = '0;
        if (dvi && dtypei == `DTYPE_FRAME_START) begin
            state_d       = ACTIVE;
            en_d          = enable;
            col_start_d   = col_start;
            col_width_d   = col_width;
            row_start_d   = row_start;
            row_height_d  = row_height;
            in_row_d      = '0;
            in_col_d      = '0;
            row_had_pix_d = 1'b0;
            cur_cols_d    = '0;
            last_cols_d   = '0;
            out_rows_d    = '0;
            dvo_d         = 1'b1;
            dtypeo_d      = dtypei;
            datao_d       = datai;
        end else if (dvi && state_q == ACTIVE) begin
            dvo_d    = 1'b1;
            dtypeo_d = dtypei;
            datao_d  = datai;
            case (dtypei)
                `DTYPE_PIXEL: begin
                    in_col_d = in_col_q + DIM_WIDTH'(1);
                    if (en_q && !(row_in && col_in)) begin
                        dvo_d = 1'b0;
                    end else begin
                        row_had_pix_d = 1'b1;
                        cur_cols_d    = cur_cols_q + DIM_WIDTH'(1);
                    end
                end
                `DTYPE_ROW_START: begin
                    if (en_q) begin
                        if (row_in) datao_d = DATA_WIDTH'(row_rel);
                        else        dvo_d   = 1'b0;
                    end
                end
                `DTYPE_ROW_END: begin
                    in_col_d      = '0;
                    in_row_d      = in_row_q + DIM_WIDTH'(1);
                    dvo_d         = !en_q || row_in;
                    out_rows_d    = rows_upd;
                    last_cols_d   = cols_upd;
                    row_had_pix_d = 1'b0;
                    cur_cols_d    = '0;
                end
                // Also closes a last row whose ROW_END was trumped by FRAME_END
                `DTYPE_FRAME_END: begin
                    out_rows_d    = rows_upd;
                    last_cols_d   = cols_upd;
                    row_had_pix_d = 1'b0;
                    cur_cols_d    = '0;
                    num_rows_d    = rows_upd;
                    num_cols_d    = cols_upd;
                end
                default: ;
            endcase
            if (!dvo_d) begin
                dtypeo_d = '0;
                datao_d  = '0;
            end
        end
    end

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            state_q       <= WAIT_FS;
            en_q          <= 1'b0;
            col_start_q   <= '0;
            col_width_q   <= '0;
            row_start_q   <= '0;
            row_height_q  <= '0;
            in_row_q      <= '0;
            in_col_q      <= '0;
            row_had_pix_q <= 1'b0;
            cur_cols_q    <= '0;
            last_cols_q   <= '0;
            out_rows_q    <= '0;
            num_rows_q    <= '0;
            num_cols_q    <= '0;
            dvo_q         <= 1'b0;
            dtypeo_q      <= '0;
            datao_q       <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            col_start_q   <= col_start_d;
            col_width_q   <= col_width_d;
            row_start_q   <= row_start_d;
            row_height_q  <= row_height_d;
            in_row_q      <= in_row_d;
            in_col_q      <= in_col_d;
            row_had_pix_q <= row_had_pix_d;
            cur_cols_q    <= cur_cols_d;
            last_cols_q   <= last_cols_d;
            out_rows_q    <= out_rows_d;
            num_rows_q    <= num_rows_d;
            num_cols_q    <= num_cols_d;
            dvo_q         <= dvo_d;
            dtypeo_q      <= dtypeo_d;
            datao_q       <= datao_d;
        end
    end

    assign dvo          = dvo_q;
    assign dtypeo       = dtypeo_q;
    assign datao        = datao_q;
    assign num_rows_out = num_rows_q;
    assign num_cols_out = num_cols_q;

endmodule

// File: tb/tb_imager_crop.sv
// tb/tb_imager_crop.sv - scoreboard bench for imager_crop
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h5
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'h6
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'h7
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'h8
`endif

module tb_imager_crop;

    logic        clki = 1'b0;
    logic        resetb_clki;
    logic        enable;
    logic [15:0] col_start, col_width, row_start, row_height;
    logic        dvi;
    logic [3:0]  dtypei;
    logic [15:0] datai;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao;
    logic [15:0] num_rows_out, num_cols_out;

    always #5 clki = ~clki;

    imager_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
        .clki(clki), .resetb_clki(resetb_clki), .enable(enable),
        .col_start(col_start), .col_width(col_width),
        .row_start(row_start), .row_height(row_height),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
        .num_rows_out(num_rows_out), .num_cols_out(num_cols_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pix_seen, re_seen, hdr_seen;
    logic [20:0] exp_q[$];

    bit m_active, m_en;
    int m_cs, m_cw, m_rs, m_rh, m_row, m_col, m_had, m_cur, m_rows, m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_active = 0; m_en = 0;
        m_cs = 0; m_cw = 0; m_rs = 0; m_rh = 0;
        m_row = 0; m_col = 0; m_had = 0; m_cur = 0; m_rows = 0; m_last = 0;
        exp_q.delete();
    endtask

    task automatic close_row();
        if (m_had != 0) begin
            m_rows++;
            m_last = m_cur;
            m_had  = 0;
            m_cur  = 0;
        end
    endtask

    task automatic model(input logic v, input logic [3:0] t, input logic [15:0] d, output logic [20:0] e);
        bit rin, cin;
        e = '0;
        if (v) begin
            if (t == `DTYPE_FRAME_START) begin
                m_active = 1; m_en = enable;
                m_cs = int'(col_start); m_cw = int'(col_width);
                m_rs = int'(row_start); m_rh = int'(row_height);
                m_row = 0; m_col = 0; m_had = 0; m_cur = 0; m_rows = 0; m_last = 0;
                e = {1'b1, t, d};
            end else if (m_active) begin
                rin = (m_row >= m_rs) && (m_row < m_rs + m_rh);
                cin = (m_col >= m_cs) && (m_col < m_cs + m_cw);
                case (t)
                    `DTYPE_PIXEL: begin
                        if (!m_en || (rin && cin)) begin
                            e = {1'b1, t, d};
                            m_had = 1;
                            m_cur++;
                        end
                        m_col++;
                    end
                    `DTYPE_ROW_START: begin
                        if (!m_en) e = {1'b1, t, d};
                        else if (rin) e = {1'b1, t, 16'(m_row - m_rs)};
                    end
                    `DTYPE_ROW_END: begin
                        if (!m_en || rin) e = {1'b1, t, d};
                        close_row();
                        m_col = 0;
                        m_row++;
                    end
                    `DTYPE_FRAME_END: begin
                        e = {1'b1, t, d};
                        close_row();
                    end
                    default: e = {1'b1, t, d};
                endcase
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after comparing the output
    task automatic send(input logic v, input logic [3:0] t, input logic [15:0] d);
        logic [20:0] e;
        dvi = v; dtypei = t; datai = d;
        model(v, t, d, e);
        exp_q.push_back(e);
        @(posedge clki);
        @(negedge clki);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("token", {11'd0, dvo, dtypeo, datao}, {11'd0, e});
        end
        if (dvo && dtypeo == `DTYPE_PIXEL) pix_seen++;
        if (dvo && dtypeo == `DTYPE_ROW_END) re_seen++;
        if (dvo && (dtypeo == `DTYPE_HEADER_START || dtypeo == `DTYPE_HEADER ||
                    dtypeo == `DTYPE_HEADER_END)) hdr_seen++;
    endtask

    task automatic gap();
        send(1'b0, 4'($urandom_range(0, 15)), 16'($urandom));
    endtask

    task automatic set_win(input int cs, input int cw, input int rs, input int rh);
        col_start = 16'(cs); col_width = 16'(cw); row_start = 16'(rs); row_height = 16'(rh);
    endtask

    task automatic frame(input int nr, input int nc, input bit trump, input int raise_row);
        pix_seen = 0; re_seen = 0;
        send(1'b1, `DTYPE_FRAME_START, 16'h00F5);
        for (int r = 0; r < nr; r++) begin
            if (r == raise_row) enable = 1'b1;
            if (r > 0) send(1'b1, `DTYPE_ROW_START, 16'(16'hA000 + r));
            for (int c = 0; c < nc; c++) begin
                if ($urandom_range(0, 5) == 0) gap();
                send(1'b1, `DTYPE_PIXEL, 16'(r * 256 + c + 16'h1000));
            end
            if (!(trump && r == nr - 1)) send(1'b1, `DTYPE_ROW_END, 16'(16'hB000 + r));
        end
        send(1'b1, `DTYPE_FRAME_END, 16'hE00E);
    endtask

    task automatic check_dims(input string tag, input int rows, input int cols);
        check({tag, "_rows"}, 32'(num_rows_out), 32'(rows));
        check({tag, "_cols"}, 32'(num_cols_out), 32'(cols));
    endtask

    initial begin
        resetb_clki = 1'b0; enable = 1'b0; set_win(0, 0, 0, 0);
        dvi = 1'b0; dtypei = '0; datai = '0;
        model_reset();
        repeat (3) @(posedge clki);
        @(negedge clki);
        check("rst_out", {11'd0, dvo, dtypeo, datao}, 32'd0);
        check_dims("rst", 0, 0);
        resetb_clki = 1'b1;

        // Tokens before the first FRAME_START are dropped
        enable = 1'b1; set_win(2, 3, 1, 2);
        pix_seen = 0;
        for (int i = 0; i < 10; i++) send(1'b1, `DTYPE_PIXEL, 16'(i + 1));
        check("pre_fs_pix", pix_seen, 0);
        send(1'b1, `DTYPE_FRAME_START, 16'd5);
        check("fs_out", {11'd0, dvo, dtypeo, datao}, {11'd0, 1'b1, `DTYPE_FRAME_START, 16'd5});
        check_dims("pre_fs", 0, 0);
        send(1'b1, `DTYPE_FRAME_END, 16'd0);
        check_dims("empty", 0, 0);

        frame(6, 8, 1'b0, -1);
        check("basic_pix", pix_seen, 6);
        check("basic_re", re_seen, 2);
        check_dims("basic", 2, 3);

        set_win(6, 10, 4, 10);
        frame(6, 8, 1'b1, -1);
        check("clip_pix", pix_seen, 4);
        check_dims("clip", 2, 2);

        // Bypass latched at FS; raising enable mid-frame must not take effect
        enable = 1'b0; set_win(2, 3, 1, 2);
        frame(6, 8, 1'b0, 2);
        check("byp_pix", pix_seen, 48);
        check("byp_re", re_seen, 6);
        check_dims("byp", 6, 8);
        frame(6, 8, 1'b0, -1);
        check("recrop_pix", pix_seen, 6);
        check_dims("recrop", 2, 3);

        hdr_seen = 0;
        send(1'b1, `DTYPE_HEADER_START, 16'h4800);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) gap();
            send(1'b1, `DTYPE_HEADER, 16'($urandom));
        end
        gap();
        send(1'b1, `DTYPE_HEADER_END, 16'h48FF);
        check("hdr_cnt", hdr_seen, 18);

        set_win(2, 3, 1, 0);
        frame(6, 8, 1'b0, -1);
        check("zero_pix", pix_seen, 0);
        check("zero_re", re_seen, 0);
        check_dims("zero", 0, 0);

        set_win(2, 3, 1, 2);
        frame(6, 8, 1'b0, -1);
        check_dims("pre_rst", 2, 3);

        // Reset in the middle of a frame, at pixel 20
        send(1'b1, `DTYPE_FRAME_START, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, `DTYPE_PIXEL, 16'(i));
            if (i % 8 == 7) send(1'b1, `DTYPE_ROW_END, 16'(i));
        end
        resetb_clki = 1'b0;
        dvi = 1'b0;
        #1;
        check("mrst_out", {11'd0, dvo, dtypeo, datao}, 32'd0);
        check_dims("mrst", 0, 0);
        model_reset();
        @(posedge clki);
        @(posedge clki);
        @(negedge clki);
        resetb_clki = 1'b1;
        pix_seen = 0; re_seen = 0;
        for (int i = 20; i < 48; i++) begin
            send(1'b1, `DTYPE_PIXEL, 16'(i));
            if (i % 8 == 7) send(1'b1, `DTYPE_ROW_END, 16'(i));
        end
        send(1'b1, `DTYPE_FRAME_END, 16'h0002);
        check("post_rst_pix", pix_seen, 0);
        check("post_rst_re", re_seen, 0);
        check_dims("post_rst", 0, 0);
        send(1'b1, `DTYPE_FRAME_START, 16'h0033);
        check("post_rst_fs", {11'd0, dvo, dtypeo, datao}, {11'd0, 1'b1, `DTYPE_FRAME_START, 16'h0033});
        gap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
